// File: rtl/stage_wb.sv
// stage_wb: writeback stage of the Noname RV32 pipeline.
// Commits ALU results and completed Wishbone loads/stores to the register
// file, and turns memory-stage faults into one precise exception pulse.
// Optional feature macro: WB_BUS_TIMEOUT_EN adds a wait-cycle counter that
// raises an access fault when a bus access hangs for TIMEOUT_CYCLES cycles.
module stage_wb #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        rd_we_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] alu_result_i,
    input  logic        is_ld_mem_i,
    input  logic        is_st_mem_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i,
    input  logic        mem_err_i,
    input  logic        e_ld_addr_mis_i,
    input  logic        e_st_addr_mis_i,
    output logic        stall_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        retire_o,
    output logic        exc_valid_o,
    output logic [3:0]  exc_cause_o,
    output logic [31:0] exc_pc_o,
    output logic [31:0] exc_tval_o
);

    // mcause codes for memory faults
    localparam logic [3:0] CAUSE_LD_MIS = 4'd4;
    localparam logic [3:0] CAUSE_LD_ACC = 4'd5;
    localparam logic [3:0] CAUSE_ST_MIS = 4'd6;
    localparam logic [3:0] CAUSE_ST_ACC = 4'd7;

    typedef enum logic [1:0] {IDLE, WAIT_MEM, TRAP} state_t;

    // TIMEOUT_CYCLES must fit the 8-bit wait counter (1..255)
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_out_of_range
    end

    state_t      state_q, state_d;

    // Instruction latched while its bus access is outstanding
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_we_q, rd_we_d;
    logic        is_ld_q, is_ld_d;

    // Exception record held in TRAP until it is published
    logic [3:0]  trap_cause_q, trap_cause_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic [31:0] trap_tval_q, trap_tval_d;

    // Registered outputs
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        retire_q, retire_d;
    logic        exc_valid_q, exc_valid_d;
    logic [3:0]  exc_cause_q, exc_cause_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic [31:0] exc_tval_q, exc_tval_d;

`ifdef WB_BUS_TIMEOUT_EN
    // The counter reaches TIMEOUT_CYCLES on the wait cycle whose edge traps,
    // so compare against the value it holds during that last cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  wait_cnt_q, wait_cnt_d;
`endif

    // Next-state, commit and exception logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        rd_d         = rd_q;
        rd_we_d      = rd_we_q;
        is_ld_d      = is_ld_q;
        trap_cause_d = trap_cause_q;
        trap_pc_d    = trap_pc_q;
        trap_tval_d  = trap_tval_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        retire_d     = 1'b0;
        exc_valid_d  = 1'b0;
        exc_cause_d  = exc_cause_q;
        exc_pc_d     = exc_pc_q;
        exc_tval_d   = exc_tval_q;
        stall_o      = 1'b0;
`ifdef WB_BUS_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (e_ld_addr_mis_i || e_st_addr_mis_i) begin
                        stall_o      = 1'b1;
                        trap_cause_d = e_ld_addr_mis_i ? CAUSE_LD_MIS : CAUSE_ST_MIS;
                        trap_pc_d    = pc_i;
                        trap_tval_d  = mem_addr_i;
                        state_d      = TRAP;
                    end else if (is_ld_mem_i || is_st_mem_i) begin
                        stall_o = 1'b1;
                        pc_d    = pc_i;
                        addr_d  = mem_addr_i;
                        rd_d    = rd_addr_i;
                        rd_we_d = rd_we_i;
                        is_ld_d = is_ld_mem_i;
                        state_d = WAIT_MEM;
`ifdef WB_BUS_TIMEOUT_EN
                        wait_cnt_d = 8'd0;
`endif
                    end else begin
                        rf_we_d    = rd_we_i && (rd_addr_i != 5'd0);
                        rf_waddr_d = rd_addr_i;
                        rf_wdata_d = alu_result_i;
                        retire_d   = 1'b1;
                    end
                end
            end

            WAIT_MEM: begin
                stall_o = 1'b1;
                if (mem_err_i) begin
                    trap_cause_d = is_ld_q ? CAUSE_LD_ACC : CAUSE_ST_ACC;
                    trap_pc_d    = pc_q;
                    trap_tval_d  = addr_q;
                    state_d      = TRAP;
                end else if (mem_ack_i) begin
                    // Stores retire without touching the register file
                    rf_we_d  = is_ld_q && rd_we_q && (rd_q != 5'd0);
                    retire_d = 1'b1;
                    if (is_ld_q) begin
                        rf_waddr_d = rd_q;
                        rf_wdata_d = mem_data_i;
                    end
                    state_d = IDLE;
                end
`ifdef WB_BUS_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LAST) begin
                    trap_cause_d = is_ld_q ? CAUSE_LD_ACC : CAUSE_ST_ACC;
                    trap_pc_d    = pc_q;
                    trap_tval_d  = addr_q;
                    state_d      = TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end

            TRAP: begin
                stall_o     = 1'b1;
                exc_valid_d = 1'b1;
                exc_cause_d = trap_cause_q;
                exc_pc_d    = trap_pc_q;
                exc_tval_d  = trap_tval_q;
                state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            addr_q       <= '0;
            rd_q         <= '0;
            rd_we_q      <= 1'b0;
            is_ld_q      <= 1'b0;
            trap_cause_q <= '0;
            trap_pc_q    <= '0;
            trap_tval_q  <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            retire_q     <= 1'b0;
            exc_valid_q  <= 1'b0;
            exc_cause_q  <= '0;
            exc_pc_q     <= '0;
            exc_tval_q   <= '0;
`ifdef WB_BUS_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            rd_q         <= rd_d;
            rd_we_q      <= rd_we_d;
            is_ld_q      <= is_ld_d;
            trap_cause_q <= trap_cause_d;
            trap_pc_q    <= trap_pc_d;
            trap_tval_q  <= trap_tval_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            retire_q     <= retire_d;
            exc_valid_q  <= exc_valid_d;
            exc_cause_q  <= exc_cause_d;
            exc_pc_q     <= exc_pc_d;
            exc_tval_q   <= exc_tval_d;
`ifdef WB_BUS_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign rf_we_o     = rf_we_q;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign retire_o    = retire_q;
    assign exc_valid_o = exc_valid_q;
    assign exc_cause_o = exc_cause_q;
    assign exc_pc_o    = exc_pc_q;
    assign exc_tval_o  = exc_tval_q;

endmodule

// File: tb/tb_stage_wb.sv
// tb_stage_wb: directed, table-driven bench for stage_wb.
// Build with WB_BUS_TIMEOUT_EN defined to exercise the bus timeout path.
module tb_stage_wb;

`ifdef WB_BUS_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] pc_i;
    logic        rd_we_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] alu_result_i;
    logic        is_ld_mem_i, is_st_mem_i;
    logic [31:0] mem_addr_i, mem_data_i;
    logic        mem_ack_i, mem_err_i;
    logic        e_ld_addr_mis_i, e_st_addr_mis_i;
    logic        stall_o, rf_we_o, retire_o, exc_valid_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o, exc_pc_o, exc_tval_o;
    logic [3:0]  exc_cause_o;

    int checks = 0;
    int errors = 0;

    stage_wb #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
        .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .alu_result_i(alu_result_i),
        .is_ld_mem_i(is_ld_mem_i), .is_st_mem_i(is_st_mem_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i),
        .e_ld_addr_mis_i(e_ld_addr_mis_i), .e_st_addr_mis_i(e_st_addr_mis_i),
        .stall_o(stall_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o), .retire_o(retire_o), .exc_valid_o(exc_valid_o),
        .exc_cause_o(exc_cause_o), .exc_pc_o(exc_pc_o), .exc_tval_o(exc_tval_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        valid;
        logic        rd_we;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic        exp_retire;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        valid_i = 0; pc_i = 0; rd_we_i = 0; rd_addr_i = 0; alu_result_i = 0;
        is_ld_mem_i = 0; is_st_mem_i = 0; mem_addr_i = 0; mem_data_i = 0;
        mem_ack_i = 0; mem_err_i = 0; e_ld_addr_mis_i = 0; e_st_addr_mis_i = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall_o), 0);
        chk({tag, "_rf_we"}, 32'(rf_we_o), 0);
        chk({tag, "_waddr"}, 32'(rf_waddr_o), 0);
        chk({tag, "_wdata"}, rf_wdata_o, 0);
        chk({tag, "_retire"}, 32'(retire_o), 0);
        chk({tag, "_exc_valid"}, 32'(exc_valid_o), 0);
        chk({tag, "_exc_cause"}, 32'(exc_cause_o), 0);
        chk({tag, "_exc_pc"}, exc_pc_o, 0);
        chk({tag, "_exc_tval"}, exc_tval_o, 0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   bad;
        vecs[0] = '{1, 1, 5'd5,  32'h1234_5678, 1, 5'd5,  32'h1234_5678, 1};
        vecs[1] = '{1, 1, 5'd31, 32'hFFFF_FFFF, 1, 5'd31, 32'hFFFF_FFFF, 1};
        vecs[2] = '{1, 1, 5'd0,  32'hAAAA_5555, 0, 5'd0,  32'h0,         1};
        vecs[3] = '{0, 1, 5'd9,  32'h0000_0001, 0, 5'd0,  32'h0,         0};
        vecs[4] = '{1, 0, 5'd4,  32'h0000_0077, 0, 5'd0,  32'h0,         1};
        vecs[5] = '{1, 1, 5'd1,  32'h0000_0000, 1, 5'd1,  32'h0000_0000, 1};

        clear_inputs();
        rst_i = 1;
        repeat (3) step();
        rst_i = 0;
        check_all_zero("reset");

        // Back-to-back non-memory instructions, one per cycle
        for (int i = 0; i < 6; i++) begin
            valid_i = vecs[i].valid; rd_we_i = vecs[i].rd_we;
            rd_addr_i = vecs[i].rd; alu_result_i = vecs[i].alu; pc_i = 32'(i * 4);
            #1;
            chk($sformatf("alu%0d_stall", i), 32'(stall_o), 0);
            step();
            chk($sformatf("alu%0d_rf_we", i), 32'(rf_we_o), 32'(vecs[i].exp_we));
            chk($sformatf("alu%0d_retire", i), 32'(retire_o), 32'(vecs[i].exp_retire));
            chk($sformatf("alu%0d_exc", i), 32'(exc_valid_o), 0);
            if (vecs[i].exp_we) begin
                chk($sformatf("alu%0d_waddr", i), 32'(rf_waddr_o), 32'(vecs[i].exp_waddr));
                chk($sformatf("alu%0d_wdata", i), rf_wdata_o, vecs[i].exp_wdata);
            end
            $display("alu vector %0d: we=%0b waddr=%0d wdata=%08h retire=%0b",
                     i, rf_we_o, rf_waddr_o, rf_wdata_o, retire_o);
        end
        clear_inputs();
        step();

        // Load, ack three cycles after accept: stall four cycles
        valid_i = 1; is_ld_mem_i = 1; rd_we_i = 1; rd_addr_i = 3;
        mem_addr_i = 32'h2000; pc_i = 32'h40;
        #1;
        chk("ld_stall_c0", 32'(stall_o), 1);
        step();
        clear_inputs();
        #1;
        chk("ld_stall_c1", 32'(stall_o), 1);
        chk("ld_no_early_we", 32'(rf_we_o), 0);
        step();
        chk("ld_stall_c2", 32'(stall_o), 1);
        step();
        mem_ack_i = 1; mem_data_i = 32'hDEAD_BEEF;
        #1;
        chk("ld_stall_c3", 32'(stall_o), 1);
        step();
        clear_inputs();
        #1;
        chk("ld_stall_done", 32'(stall_o), 0);
        chk("ld_rf_we", 32'(rf_we_o), 1);
        chk("ld_waddr", 32'(rf_waddr_o), 3);
        chk("ld_wdata", rf_wdata_o, 32'hDEAD_BEEF);
        chk("ld_retire", 32'(retire_o), 1);
        $display("load: we=%0b waddr=%0d wdata=%08h", rf_we_o, rf_waddr_o, rf_wdata_o);
        step();
        chk("ld_we_pulse", 32'(rf_we_o), 0);

        // Store with ack on the next cycle
        valid_i = 1; is_st_mem_i = 1; mem_addr_i = 32'h2004; pc_i = 32'h44;
        step();
        clear_inputs();
        mem_ack_i = 1;
        step();
        clear_inputs();
        chk("st_retire", 32'(retire_o), 1);
        chk("st_rf_we", 32'(rf_we_o), 0);
        $display("store: retire=%0b we=%0b", retire_o, rf_we_o);
        step();

        // Misaligned load
        valid_i = 1; is_ld_mem_i = 1; e_ld_addr_mis_i = 1; rd_we_i = 1; rd_addr_i = 7;
        mem_addr_i = 32'h1001; pc_i = 32'h80;
        step();
        clear_inputs();
        #1;
        chk("mis_trap_stall", 32'(stall_o), 1);
        chk("mis_no_early_exc", 32'(exc_valid_o), 0);
        step();
        chk("mis_exc_valid", 32'(exc_valid_o), 1);
        chk("mis_cause", 32'(exc_cause_o), 4);
        chk("mis_pc", exc_pc_o, 32'h80);
        chk("mis_tval", exc_tval_o, 32'h1001);
        chk("mis_no_we", 32'(rf_we_o), 0);
        chk("mis_no_retire", 32'(retire_o), 0);
        $display("ld misalign: exc=%0b cause=%0d pc=%08h tval=%08h",
                 exc_valid_o, exc_cause_o, exc_pc_o, exc_tval_o);
        step();
        chk("mis_exc_pulse", 32'(exc_valid_o), 0);
        chk("mis_stall_done", 32'(stall_o), 0);

        // Misaligned store
        valid_i = 1; is_st_mem_i = 1; e_st_addr_mis_i = 1; mem_addr_i = 32'h1002; pc_i = 32'h84;
        step();
        clear_inputs();
        step();
        chk("stmis_cause", 32'(exc_cause_o), 6);
        chk("stmis_tval", exc_tval_o, 32'h1002);
        $display("st misalign: exc=%0b cause=%0d", exc_valid_o, exc_cause_o);
        step();

        // Store bus error, with ack also high: err wins
        valid_i = 1; is_st_mem_i = 1; mem_addr_i = 32'h3000; pc_i = 32'h90;
        step();
        clear_inputs();
        mem_err_i = 1; mem_ack_i = 1;
        step();
        clear_inputs();
        chk("sterr_no_retire", 32'(retire_o), 0);
        chk("sterr_no_early_exc", 32'(exc_valid_o), 0);
        step();
        chk("sterr_exc_valid", 32'(exc_valid_o), 1);
        chk("sterr_cause", 32'(exc_cause_o), 7);
        chk("sterr_pc", exc_pc_o, 32'h90);
        chk("sterr_tval", exc_tval_o, 32'h3000);
        $display("st buserr: exc=%0b cause=%0d pc=%08h tval=%08h",
                 exc_valid_o, exc_cause_o, exc_pc_o, exc_tval_o);
        step();

        // Load bus error
        valid_i = 1; is_ld_mem_i = 1; rd_we_i = 1; rd_addr_i = 2; mem_addr_i = 32'h3100; pc_i = 32'h94;
        step();
        clear_inputs();
        mem_err_i = 1;
        step();
        clear_inputs();
        step();
        chk("lderr_cause", 32'(exc_cause_o), 5);
        chk("lderr_no_we", 32'(rf_we_o), 0);
        $display("ld buserr: exc=%0b cause=%0d", exc_valid_o, exc_cause_o);
        step();

        // Load that never acks
        valid_i = 1; is_ld_mem_i = 1; rd_we_i = 1; rd_addr_i = 6; mem_addr_i = 32'h4000; pc_i = 32'hA0;
        step();
        clear_inputs();
`ifdef WB_BUS_TIMEOUT_EN
        repeat (3) step();
        chk("to_still_waiting", 32'(stall_o), 1);
        chk("to_no_early_exc", 32'(exc_valid_o), 0);
        step();
        chk("to_trap_no_exc_yet", 32'(exc_valid_o), 0);
        step();
        chk("to_exc_valid", 32'(exc_valid_o), 1);
        chk("to_cause", 32'(exc_cause_o), 5);
        chk("to_pc", exc_pc_o, 32'hA0);
        chk("to_tval", exc_tval_o, 32'h4000);
        $display("timeout: exc=%0b cause=%0d tval=%08h", exc_valid_o, exc_cause_o, exc_tval_o);
        step();
        // Fresh access to abandon with reset
        valid_i = 1; is_ld_mem_i = 1; rd_we_i = 1; rd_addr_i = 8; mem_addr_i = 32'h5000; pc_i = 32'hB0;
        step();
        clear_inputs();
        step();
`else
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            if (stall_o !== 1'b1 || exc_valid_o !== 1'b0) bad++;
            step();
        end
        chk("nto_stall_1000", 32'(bad), 0);
        $display("no timeout: stall held for 1000 cycles, bad=%0d", bad);
`endif

        // Reset during WAIT_MEM, then a late ack
        chk("rst_in_wait", 32'(stall_o), 1);
        rst_i = 1;
        step();
        rst_i = 0;
        mem_ack_i = 1; mem_data_i = 32'hCAFE_F00D;
        step();
        clear_inputs();
        step();
        check_all_zero("rst_mid");
        $display("reset mid-access: we=%0b exc=%0b stall=%0b", rf_we_o, exc_valid_o, stall_o);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_wb.md
# stage_wb

Writeback stage of the Noname RV32 pipeline, directly downstream of the memory stage. Accepts one retiring instruction per cycle, waits for the Wishbone completion of loads and stores, writes the result to the register file, and turns memory-stage faults (misalignment, bus error, optional bus timeout) into a single precise exception record for the trap logic. While a bus access is outstanding it stalls everything upstream.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, cycles `WAIT_MEM` tolerates without ack or err before declaring an access fault. Only used with `WB_BUS_TIMEOUT_EN`. Range 1..255.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  instruction present from the memory stage this cycle
- pc_i  in  32  PC of that instruction
- rd_we_i  in  1  instruction writes rd
- rd_addr_i  in  5  destination register
- alu_result_i  in  32  non-memory result
- is_ld_mem_i / is_st_mem_i  in  1 each  load / store
- mem_addr_i  in  32  effective address
- mem_data_i  in  32  formatted load data; valid at the rising edge on which mem_ack_i is high
- mem_ack_i / mem_err_i  in  1 each  Wishbone ack / err
- e_ld_addr_mis_i / e_st_addr_mis_i  in  1 each  misalignment flags from the memory stage
- stall_o  out  1  hold upstream stages; the current instruction is not consumed
- rf_we_o  out  1  register-file write strobe, one-cycle pulse
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  32  write data; also the forwarding source while rf_we_o=1
- retire_o  out  1  one-cycle pulse per committed instruction (instret)
- exc_valid_o  out  1  one-cycle exception pulse
- exc_cause_o  out  4  mcause code
- exc_pc_o  out  32  faulting PC
- exc_tval_o  out  32  faulting address

## Operation
- FSM states: `IDLE`, `WAIT_MEM`, `TRAP`. Reset puts it in `IDLE` and sets every output to 0.
- `IDLE`, valid_i=1:
  - A misalignment flag is set: go to `TRAP`. Cause 4 for a load, 6 for a store. tval=mem_addr_i.
  - The instruction is a load or store: latch pc, rd, rd_we, is_ld and the address, then go to `WAIT_MEM`. stall_o=1 combinationally in this same cycle.
  - Otherwise: commit alu_result_i. Stay in `IDLE`.
- `WAIT_MEM`: stall_o=1.
  - mem_ack_i=1: commit. A load writes mem_data_i. A store writes nothing but still pulses retire_o. Return to `IDLE`.
  - mem_err_i=1 (takes priority over ack): go to `TRAP`. Cause 5 for a load, 7 for a store.
- `TRAP`: stall_o=1.
  - Next edge: exc_valid_o=1 for one cycle with cause/pc/tval. No rf write, no retire.
  - Then return to `IDLE`.
- Commit: rf_we_o = rd_we && rd!=0, registered. Writes to x0 are suppressed but the instruction still retires.
- valid_i=0 in `IDLE`: outputs rf_we_o/retire_o/exc_valid_o are 0 on the next cycle.
- rst_i mid-access: the state is dropped and no commit or exception is issued for the outstanding access.

## Timing
- Non-memory instruction: rf_we_o/retire_o assert 1 cycle after the accept edge.
- Load/store: stall_o high from the accept cycle through the ack cycle. Commit outputs appear 1 cycle after the ack edge. Minimum latency is 2 cycles when ack arrives the cycle after accept.
- Exceptions: exc_valid_o appears 2 cycles after the detect edge: detect edge → `TRAP`, then one edge to pulse.
- Back-to-back non-memory instructions: one per cycle, no bubble.
- stall_o is combinational from state and the inputs in `IDLE`. All other outputs are registered.

## Configuration
- `WB_BUS_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to `WAIT_MEM` and increments each cycle without ack/err.
  - When the counter reaches TIMEOUT_CYCLES, go to `TRAP` with an access-fault cause (5 or 7) and tval = the latched address.
  - An ack on the same cycle as the timeout wins.
- Not defined: no counter, and `WAIT_MEM` waits indefinitely.

## Test plan
- ALU op, rd=5, result 0x1234_5678 → next cycle: rf_we_o=1, waddr=5, wdata=0x12345678, retire_o=1, stall_o=0.
- Load rd=3 with ack 3 cycles later, mem_data_i=0xDEAD_BEEF → stall_o high 4 cycles, then rf_we_o=1, wdata=0xDEADBEEF.
- Store with ack → retire_o=1, rf_we_o=0. ALU op with rd=0 → retire_o=1, rf_we_o=0.
- Load, e_ld_addr_mis_i=1, addr 0x1001, pc 0x80 → exc_valid_o pulse, cause=4, tval=0x1001, pc=0x80, no write. Store with mem_err_i → cause=7.
- With the macro defined and TIMEOUT_CYCLES=4, a load that never acks → exc cause=5 after 4 wait cycles. Without the macro, stall_o stays high for 1000 cycles.
- rst_i asserted in `WAIT_MEM`, then ack arrives → no rf_we_o or exc_valid_o, and all outputs are 0.
